// File: rtl/svga_timing_gen.sv
// SVGA raster timing generator: waits for a settled PLL lock, then runs an
// 800x600@60 raster with registered, mutually aligned sync/strobe/coordinate outputs.
`timescale 1ns/1ps
module svga_timing_gen #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 128,
    parameter int H_BP        = 88,
    parameter int V_ACTIVE    = 600,
    parameter int V_FP        = 1,
    parameter int V_SYNC      = 4,
    parameter int V_BP        = 23,
    parameter bit SYNC_POS    = 1'b1,
    parameter int LOCK_STABLE = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        locked,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start,
    output logic        running
);

    localparam int SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;

    localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_STABLE - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_lock_meta;
    logic          r_lock_s;
    logic [SW-1:0] r_cnt;
    logic [SW-1:0] w_cnt_nxt;
    logic [10:0]   r_x;
    logic [10:0]   w_x_nxt;
    logic [9:0]    r_y;
    logic [9:0]    w_y_nxt;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_active;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_running;
    logic          w_run_nxt;
    logic          w_hs_win;
    logic          w_vs_win;

    // Two-flop synchroniser for the asynchronous PLL lock flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Next state, settle count and raster position; anything but a locked RUN parks x/y at 0
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = 11'd0;
        w_y_nxt     = 10'd0;
        case (r_state)
            ST_WAIT: begin
                w_cnt_nxt = {SW{1'b0}};
                if (r_lock_s) begin
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_SETTLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = {SW{1'b0}};
                end else if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = {SW{1'b0}};
                end else begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = r_cnt + {{(SW-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                w_cnt_nxt = {SW{1'b0}};
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_RUN;
                    if (r_x == H_LAST) begin
                        w_x_nxt = 11'd0;
                        if (r_y == V_LAST) begin
                            w_y_nxt = 10'd0;
                        end else begin
                            w_y_nxt = r_y + 10'd1;
                        end
                    end else begin
                        w_x_nxt = r_x + 11'd1;
                        w_y_nxt = r_y;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = {SW{1'b0}};
            end
        endcase
    end

    // Strobes decoded from the next coordinates so they land in the same cycle as x/y
    assign w_run_nxt = (w_state_nxt == ST_RUN);
    assign w_hs_win  = (w_x_nxt >= HS_START) && (w_x_nxt < HS_END);
    assign w_vs_win  = (w_y_nxt >= VS_START) && (w_y_nxt < VS_END);

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_WAIT;
            r_cnt         <= {SW{1'b0}};
            r_x           <= 11'd0;
            r_y           <= 10'd0;
            r_hsync       <= ~SYNC_POS;
            r_vsync       <= ~SYNC_POS;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_hsync       <= (w_run_nxt && w_hs_win) ? SYNC_POS : ~SYNC_POS;
            r_vsync       <= (w_run_nxt && w_vs_win) ? SYNC_POS : ~SYNC_POS;
            r_active      <= w_run_nxt && (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
            r_line_start  <= w_run_nxt && (w_x_nxt == 11'd0);
            r_frame_start <= w_run_nxt && (w_x_nxt == 11'd0) && (w_y_nxt == 10'd0);
            r_running     <= w_run_nxt;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign running     = r_running;

endmodule

// File: tb/tb_svga_timing_gen.sv
// Directed bench: default 800x600 geometry (active-high syncs) plus a shrunken
// geometry with active-low syncs so full-frame timing fits in a short run.
`timescale 1ns/1ps
module tb_svga_timing_gen;

    localparam int LS_A = 4;
    localparam int LS_B = 3;

    logic        clk;
    logic        reset_n;
    logic        lock_a;
    logic        lock_b;

    logic        hs_a, vs_a, act_a, ls_a, fs_a, run_a;
    logic [10:0] x_a;
    logic [9:0]  y_a;
    logic        hs_b, vs_b, act_b, ls_b, fs_b, run_b;
    logic [10:0] x_b;
    logic [9:0]  y_b;

    int n_pass = 0;
    int n_tot  = 0;

    svga_timing_gen #(.LOCK_STABLE(LS_A)) dut_a (
        .clock(clk), .reset_n(reset_n), .locked(lock_a),
        .hsync(hs_a), .vsync(vs_a), .active(act_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a), .running(run_a)
    );

    // 16x10 raster: active 8x6, hsync x=10..12, vsync y=7..8, frame = 160 cycles
    svga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POS(1'b0), .LOCK_STABLE(LS_B)
    ) dut_b (
        .clock(clk), .reset_n(reset_n), .locked(lock_b),
        .hsync(hs_b), .vsync(vs_b), .active(act_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b), .running(run_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   t;
        int   ex;
        int   ey;
        logic hs;
        logic vs;
        logic act;
        logic ls;
        logic fs;
    } vec_t;

    vec_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_tot++;
        if (act >= lo && act <= hi) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_run_a(output int k);
        k = 0;
        while (!run_a && k < 40) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_run_b(output int k);
        k = 0;
        while (!run_b && k < 40) begin
            tick();
            k++;
        end
    endtask

    initial begin
        int t;
        int k;
        int c_hs, c_vs, c_act, c_ls, c_fs;

        tbl[0]  = '{0,    0,    0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{1,    1,    0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{799,  799,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{800,  800,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{839,  839,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{840,  840,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{967,  967,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{968,  968,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1055, 1055, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1056, 0,    1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1057, 1,    1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{2952, 840,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset with lock already asserted
        reset_n = 1'b0;
        lock_a  = 1'b1;
        lock_b  = 1'b1;
        repeat (4) tick();
        chk("rst_running", run_a, 0);
        chk("rst_x", x_a, 0);
        chk("rst_y", y_a, 0);
        chk("rst_hsync", hs_a, 0);
        chk("rst_vsync", vs_a, 0);
        chk("rst_active", act_a, 0);
        chk("rst_hsync_lowpol", hs_b, 1);
        chk("rst_vsync_lowpol", vs_b, 1);

        reset_n = 1'b1;
        wait_run_a(k);
        chk_range("startup_latency", k, LS_A + 1, LS_A + 3);
        chk("start_frame_start", fs_a, 1);
        chk("start_line_start", ls_a, 1);
        chk("start_xy", {x_a, y_a}, 0);

        // Line timing table, t counted from the first RUN cycle
        t = 0;
        for (int i = 0; i < 12; i++) begin
            while (t < tbl[i].t) begin
                tick();
                t++;
            end
            chk($sformatf("v%0d_x", i), x_a, tbl[i].ex);
            chk($sformatf("v%0d_y", i), y_a, tbl[i].ey);
            chk($sformatf("v%0d_hsync", i), hs_a, tbl[i].hs);
            chk($sformatf("v%0d_vsync", i), vs_a, tbl[i].vs);
            chk($sformatf("v%0d_active", i), act_a, tbl[i].act);
            chk($sformatf("v%0d_line_start", i), ls_a, tbl[i].ls);
            chk($sformatf("v%0d_frame_start", i), fs_a, tbl[i].fs);
        end

        // One full line window: hsync width, active width, single line pulse
        c_hs = 0; c_act = 0; c_ls = 0;
        for (int i = 0; i < 1056; i++) begin
            c_hs  += int'(hs_a);
            c_act += int'(act_a);
            c_ls  += int'(ls_a);
            tick();
            t++;
        end
        chk("line_hsync_cycles", c_hs, 128);
        chk("line_active_cycles", c_act, 800);
        chk("line_start_pulses", c_ls, 1);

        // Lock loss mid-raster at x=500, y=4
        while (t < 4 * 1056 + 500) begin
            tick();
            t++;
        end
        chk("pre_loss_x", x_a, 500);
        chk("pre_loss_y", y_a, 4);
        lock_a = 1'b0;
        k = 0;
        while (run_a && k < 10) begin
            tick();
            k++;
        end
        chk_range("loss_latency", k, 2, 3);
        chk("loss_xy", {x_a, y_a}, 0);
        chk("loss_active", act_a, 0);
        chk("loss_hsync", hs_a, 0);
        chk("loss_vsync", vs_a, 0);
        chk("loss_line_start", ls_a, 0);
        lock_a = 1'b1;
        wait_run_a(k);
        chk_range("relock_latency", k, LS_A + 1, LS_A + 3);
        chk("relock_frame_start", fs_a, 1);
        chk("relock_xy", {x_a, y_a}, 0);

        // Settle abort: one-cycle lock dropout partway through SETTLE
        lock_a = 1'b0;
        repeat (6) tick();
        chk("abort_idle", run_a, 0);
        lock_a = 1'b1;
        repeat (4) tick();
        lock_a = 1'b0;
        tick();
        lock_a = 1'b1;
        k = 0;
        while (!run_a && k < 40) begin
            tick();
            k++;
        end
        chk_range("abort_restart_latency", k, LS_A + 1, LS_A + 3);
        chk("abort_frame_start", fs_a, 1);

        // Active-low instance: idle polarity, then a full frame
        lock_b = 1'b0;
        repeat (5) tick();
        chk("b_idle_running", run_b, 0);
        chk("b_idle_hsync", hs_b, 1);
        chk("b_idle_vsync", vs_b, 1);
        chk("b_idle_x", x_b, 0);
        lock_b = 1'b1;
        wait_run_b(k);
        chk_range("b_startup_latency", k, LS_B + 1, LS_B + 3);
        chk("b_frame_start", fs_b, 1);
        c_hs = 0; c_vs = 0; c_act = 0; c_ls = 0; c_fs = 0;
        for (int i = 0; i < 160; i++) begin
            c_hs  += int'(!hs_b);
            c_vs  += int'(!vs_b);
            c_act += int'(act_b);
            c_ls  += int'(ls_b);
            c_fs  += int'(fs_b);
            if (i == 111) chk("b_vsync_before", vs_b, 1);
            if (i == 112) chk("b_vsync_x0_line7", vs_b, 0);
            if (i == 159) chk("b_last_xy", {x_b, y_b}, {11'd15, 10'd9});
            tick();
        end
        chk("b_hsync_low_cycles", c_hs, 30);
        chk("b_vsync_low_cycles", c_vs, 32);
        chk("b_active_cycles", c_act, 48);
        chk("b_line_pulses", c_ls, 10);
        chk("b_frame_pulses", c_fs, 1);
        chk("b_wrap_xy", {x_b, y_b}, 0);
        chk("b_wrap_frame_start", fs_b, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
